axis_mux_sched: RTL

Frame-aware round-robin scheduler that drives the `enable`/`sel` control pins of the S_COUNT-port AXI4-Stream mux.
- Monitors per-input tvalid as request lines.
- Monitors the mux output handshake to detect frame boundaries.
- Changes `sel` only while the mux is disabled and between frames, so frames from different sources never interleave.
- Sits beside the mux in the board-level stream fabric. It is a control-only block: no datapath.

---
 rtl/axis_mux_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/axis_mux_sched.sv
// Frame-aware round-robin scheduler for an AXI4-Stream mux: drives the mux
// enable/sel pins and only moves sel between frames while the mux is disabled.
module axis_mux_sched #(
    parameter int S_COUNT          = 2,
    parameter int SEL_WIDTH        = $clog2(S_COUNT),
    parameter int FRAMES_PER_GRANT = 1,
    parameter int IDLE_TIMEOUT     = 64,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [S_COUNT-1:0]   req,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    input  logic                 mon_tlast,
    output logic                 mux_enable,
    output logic [SEL_WIDTH-1:0] mux_sel,
    output logic [S_COUNT-1:0]   grant,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic                 timeout_pulse
);

    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 enable_q, enable_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                 post_eof_q, post_eof_d;
    logic                 timeout_q, timeout_d;

    logic                 beat;
    logic                 eof;
    logic                 win_found;
    logic [SEL_WIDTH-1:0] win_idx;
    logic [SEL_WIDTH-1:0] win_next;
    logic [S_COUNT-1:0]   sel_onehot;

    assign beat       = mon_tvalid & mon_tready;
    assign eof        = beat & mon_tlast;
    assign sel_onehot = S_COUNT'(1) << sel_q;

    // Rotating search from rr_ptr; wrap is done at S_COUNT so sel stays in range.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= S_COUNT) begin
                idx = idx - S_COUNT;
            end
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = SEL_WIDTH'(idx);
            end
        end
        win_next = (int'(win_idx) == S_COUNT - 1) ? '0 : win_idx + SEL_WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        post_eof_d  = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (win_found) begin
                    sel_d    = win_idx;
                    rr_ptr_d = win_next;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (eof) begin
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                    if (int'(frame_cnt_q) + 1 >= FRAMES_PER_GRANT) begin
                        state_d     = ST_IDLE;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        post_eof_d  = 1'b1;
                    end
                end else if (post_eof_q && !req[sel_q] && ((req & ~sel_onehot) != '0)) begin
                    // Source went quiet right after its frame while others wait.
                    state_d     = ST_IDLE;
                    frame_cnt_d = '0;
                    idle_cnt_d  = '0;
                end else if (beat) begin
                    idle_cnt_d = '0;
                    if (beat_cnt_q != {CNT_WIDTH{1'b1}}) begin
                        beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
                    end
                end else if (IDLE_TIMEOUT > 0 && beat_cnt_q == '0) begin
                    if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        state_d     = ST_IDLE;
                        timeout_d   = 1'b1;
                        frame_cnt_d = '0;
                        idle_cnt_d  = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_ACTIVE) begin
            beat_cnt_d = '0;
        end
        enable_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            enable_q    <= 1'b0;
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
            idle_cnt_q  <= '0;
            post_eof_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            enable_q    <= enable_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            post_eof_q  <= post_eof_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mux_enable    = enable_q;
    assign mux_sel       = sel_q;
    assign busy          = (state_q != ST_IDLE);
    assign grant         = busy ? sel_onehot : '0;
    assign beat_count    = beat_cnt_q;
    assign timeout_pulse = timeout_q;

endmodule
